// File: rtl/mc_cpu_pkg.sv
// mc_cpu_pkg: shared state, PC-source, ALU and opcode codes for the multi-cycle MIPS core
package mc_cpu_pkg;
  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_INT = 3'd5
  } state_t;
  typedef enum logic [3:0] {
    IC_R, IC_ADDI, IC_ORI, IC_LW, IC_SW, IC_BEQ, IC_BNE, IC_J, IC_ERET, IC_ILL
  } iclass_t;
  localparam logic [2:0] PC_SRC_HOLD   = 3'd0;
  localparam logic [2:0] PC_SRC_BRANCH = 3'd1;
  localparam logic [2:0] PC_SRC_JUMP   = 3'd2;
  localparam logic [2:0] PC_SRC_INT    = 3'd3;
  localparam logic [2:0] PC_SRC_ERET   = 3'd4;
  localparam logic [2:0] PC_SRC_SEQ    = 3'd5;
  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_FUNCT = 3'd7;
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_COP0 = 6'h10;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] FN_ERET = 6'h18;
endpackage

// File: rtl/mc_instr_decode.sv
// mc_instr_decode: maps op/funct to an instruction class for the control FSM
module mc_instr_decode
  import mc_cpu_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output iclass_t    o_class
);
  assign o_class = (i_op == OP_R)    ? IC_R    :
                   (i_op == OP_ADDI) ? IC_ADDI :
                   (i_op == OP_ORI)  ? IC_ORI  :
                   (i_op == OP_LW)   ? IC_LW   :
                   (i_op == OP_SW)   ? IC_SW   :
                   (i_op == OP_BEQ)  ? IC_BEQ  :
                   (i_op == OP_BNE)  ? IC_BNE  :
                   (i_op == OP_J)    ? IC_J    :
                   (i_op == OP_COP0 && i_funct == FN_ERET) ? IC_ERET : IC_ILL;
endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle MIPS main control FSM with interrupt entry and eret
module mc_control_fsm
  import mc_cpu_pkg::*;
#(
  parameter bit INT_EN_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       irq,
  output logic [2:0] pc_source,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_b,
  output logic       ext_sel,
  output logic [2:0] alu_op,
  output logic       int_ack,
  output logic       int_en,
  output logic [2:0] state
);
  state_t  r_state, w_next, w_bnd;
  iclass_t w_class;
  logic    r_int_en, w_eret_exe;
  mc_instr_decode u_dec (.i_op(op), .i_funct(funct), .o_class(w_class));
  assign w_eret_exe = (r_state == S_EXE) && (w_class == IC_ERET);
  assign w_bnd      = (irq && (r_int_en || w_eret_exe)) ? S_INT : S_IF;
  assign state      = rst ? 3'd0 : r_state;
  assign int_en     = r_int_en & ~rst;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IF;
      r_int_en <= INT_EN_RESET;
    end else begin
      r_state  <= w_next;
      r_int_en <= (r_state == S_INT) ? 1'b0 : w_eret_exe ? 1'b1 : r_int_en;
    end
  end
  always_comb begin
    w_next     = S_IF;
    pc_source  = PC_SRC_HOLD;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_b  = 1'b0;
    ext_sel    = 1'b0;
    alu_op     = ALU_ADD;
    int_ack    = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IF: begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          pc_source = PC_SRC_SEQ;
          w_next    = S_ID;
        end
        S_ID: w_next = (w_class == IC_ILL) ? w_bnd : S_EXE;
        S_EXE: begin
          w_next = w_bnd;
          case (w_class)
            IC_R: begin
              alu_op = ALU_FUNCT;
              w_next = S_WB;
            end
            IC_ADDI: begin
              alu_src_b = 1'b1;
              ext_sel   = 1'b1;
              w_next    = S_WB;
            end
            IC_ORI: begin
              alu_op    = ALU_OR;
              alu_src_b = 1'b1;
              w_next    = S_WB;
            end
            IC_LW, IC_SW: begin
              alu_src_b = 1'b1;
              ext_sel   = 1'b1;
              w_next    = S_MEM;
            end
            IC_BEQ, IC_BNE: begin
              alu_op    = ALU_SUB;
              pc_source = PC_SRC_BRANCH;
              pc_write  = zero ^ (w_class == IC_BNE);
            end
            IC_J: begin
              pc_source = PC_SRC_JUMP;
              pc_write  = 1'b1;
            end
            IC_ERET: begin
              pc_source = PC_SRC_ERET;
              pc_write  = 1'b1;
            end
            default: w_next = w_bnd;
          endcase
        end
        S_MEM: begin
          mem_write = (w_class == IC_SW);
          w_next    = (w_class == IC_LW) ? S_WB : w_bnd;
        end
        S_WB: begin
          reg_write  = 1'b1;
          reg_dst    = (w_class == IC_R);
          mem_to_reg = (w_class == IC_LW);
          w_next     = w_bnd;
        end
        S_INT: begin
          pc_source = PC_SRC_INT;
          pc_write  = 1'b1;
          int_ack   = 1'b1;
          w_next    = S_IF;
        end
        default: w_next = S_IF;
      endcase
    end
  end
endmodule
